// File: rtl/ddr_chroma_linebuf.sv
// ddr_chroma_linebuf: single-clock line buffer for one chroma plane (U or V).
// DDR read beats (64-bit) are written sequentially from a wrapping word pointer.
// The pixel pipeline reads any byte, with a registered result one clock later.
// A clear pulse at the start of each line rewinds the write pointer.
// Optional status outputs (wcount, overflow) are built when the macro
// DDR_CHROMA_LINEBUF_STATUS_EN is defined. The data path is the same in both builds.
module ddr_chroma_linebuf #(
  parameter  int unsigned WORDS = 32,
  localparam int unsigned AW    = $clog2(WORDS),
  localparam int unsigned BAW   = AW + 3,
  localparam int unsigned CW    = AW + 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic [63:0]    wdata,
  input  logic           we,
  input  logic [BAW-1:0] raddr,
  output logic [7:0]     q
`ifdef DDR_CHROMA_LINEBUF_STATUS_EN
  ,
  output logic [CW-1:0]  wcount,
  output logic           overflow
`endif
);

  logic [63:0]   mem [WORDS];
  logic [AW-1:0] wptr;
  logic [AW-1:0] waddr_c;
  logic [63:0]   rd_word_c;

  // A clear in the same cycle as a write sends the beat to word 0.
  always_comb begin
    waddr_c   = clear ? '0 : wptr;
    rd_word_c = mem[raddr[BAW-1:3]];
  end

  // Write pointer: rewinds on clear, advances one word per beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
    end else if (we) begin
      wptr <= AW'(waddr_c + AW'(1));
    end else if (clear) begin
      wptr <= '0;
    end
  end

  // Beat storage; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr_c] <= wdata;
    end
  end

  // Registered byte read; a same-cycle write to that word returns the old byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 8'h00;
    end else begin
      q <= rd_word_c[{raddr[2:0], 3'b000} +: 8];
    end
  end

`ifdef DDR_CHROMA_LINEBUF_STATUS_EN
  // Beat count since line start (saturating) and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcount   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wcount   <= we ? CW'(1) : '0;
      overflow <= 1'b0;
    end else if (we) begin
      if (wcount == CW'(WORDS)) begin
        overflow <= 1'b1;
      end else begin
        wcount <= CW'(wcount + CW'(1));
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddr_chroma_linebuf.sv
// Scoreboard bench for ddr_chroma_linebuf: stimulus pushes expected results,
// a monitor pops and compares one entry per clock (or per reset event).
module tb_ddr_chroma_linebuf;

  logic        clk;
  logic        clk_run;
  logic        reset_n;
  logic        clear;
  logic [63:0] wdata;
  logic        we;
  logic [7:0]  raddr;
  logic [7:0]  q;
`ifdef DDR_CHROMA_LINEBUF_STATUS_EN
  logic [5:0]  wcount;
  logic        overflow;
`endif

  ddr_chroma_linebuf dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .wdata   (wdata),
    .we      (we),
    .raddr   (raddr),
    .q       (q)
`ifdef DDR_CHROMA_LINEBUF_STATUS_EN
    ,
    .wcount  (wcount),
    .overflow(overflow)
`endif
  );

  typedef struct {
    bit         chk;
    logic [7:0] q;
    int         ra;
    int         wc;
    bit         ov;
  } item_t;

  item_t exp_q[$];
  event  rst_ev;
  int    total;
  int    bad;

  // Reference model: byte-addressed line store plus line-level counters.
  logic [7:0] mb [256];
  bit         known [256];
  int         m_wptr;
  int         m_wc;
  bit         m_ov;

  // Clock that can be held still for the stopped-clock reset check.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // One clock of stimulus; the expected read/status after the edge is queued.
  task automatic step(input bit w, input bit c, input logic [63:0] d,
                      input int ra, input bit want);
    item_t it;
    we    = w;
    clear = c;
    wdata = d;
    raddr = 8'(ra);
    it.chk = want && known[ra];
    it.q   = mb[ra];
    it.ra  = ra;
    if (c) begin
      m_wptr = 0;
      m_wc   = 0;
      m_ov   = 1'b0;
    end
    if (w) begin
      if (m_wc == 32) m_ov = 1'b1;
      for (int k = 0; k < 8; k++) begin
        mb[m_wptr*8 + k]    = d[8*k +: 8];
        known[m_wptr*8 + k] = 1'b1;
      end
      m_wptr = (m_wptr + 1) % 32;
      if (m_wc < 32) m_wc++;
    end
    it.wc = m_wc;
    it.ov = m_ov;
    exp_q.push_back(it);
    @(posedge clk);
    #2;
  endtask

  // Assert reset asynchronously and queue an immediate check of q and status.
  task automatic pulse_reset();
    item_t it;
    we      = 1'b0;
    clear   = 1'b0;
    reset_n = 1'b0;
    m_wptr  = 0;
    m_wc    = 0;
    m_ov    = 1'b0;
    it.chk  = 1'b1;
    it.q    = 8'h00;
    it.ra   = -1;
    it.wc   = 0;
    it.ov   = 1'b0;
    exp_q.push_back(it);
    -> rst_ev;
    #2;
    reset_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: pops one expectation per active edge or reset event.
  initial begin
    item_t it;
    total = 0;
    bad   = 0;
    forever begin
      @(posedge clk or rst_ev);
      #1;
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        if (it.chk) begin
          total++;
          if (q !== it.q) begin
            bad++;
            $display("FAIL q raddr=%0d got=%h exp=%h t=%0t", it.ra, q, it.q, $time);
          end
        end
`ifdef DDR_CHROMA_LINEBUF_STATUS_EN
        total++;
        if (wcount !== 6'(it.wc) || overflow !== it.ov) begin
          bad++;
          $display("FAIL status got wcount=%0d ovf=%b exp wcount=%0d ovf=%b t=%0t",
                   wcount, overflow, it.wc, it.ov, $time);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mb[i]    = 8'h00;
      known[i] = 1'b0;
    end
    clk_run = 1'b0;
    reset_n = 1'b1;
    we      = 1'b0;
    clear   = 1'b0;
    wdata   = '0;
    raddr   = '0;
    m_wptr  = 0;
    m_wc    = 0;
    m_ov    = 1'b0;

    // Reset with the clock stopped, then start clocking.
    #1;
    pulse_reset();
    #1;
    clk_run = 1'b1;

    // First beat after reset lands in word 0; lane order is little-endian.
    step(1'b1, 1'b0, 64'h8877665544332211, 0, 1'b0);
    step(1'b0, 1'b0, '0, 0, 1'b1);
    step(1'b0, 1'b0, '0, 7, 1'b1);
    step(1'b0, 1'b0, '0, 3, 1'b1);

    // Sequential fill of one line then read every byte back.
    step(1'b0, 1'b1, '0, 0, 1'b1);
    for (int i = 0; i < 25; i++)
      step(1'b1, 1'b0, 64'h0706050403020100 + 64'(i) * 64'h0808080808080808,
           $urandom_range(0, 255), 1'b1);
    for (int a = 0; a < 200; a++) step(1'b0, 1'b0, '0, a, 1'b1);

    // Clear together with a write keeps the beat at word 0.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, rnd64(), $urandom_range(0, 79), 1'b1);
    step(1'b1, 1'b1, {8{8'hAA}}, 0, 1'b1);
    step(1'b1, 1'b0, {8{8'hBB}}, 0, 1'b1);
    step(1'b0, 1'b0, '0, 0, 1'b1);
    step(1'b0, 1'b0, '0, 8, 1'b1);
    step(1'b0, 1'b0, '0, 16, 1'b1);
    step(1'b0, 1'b0, '0, 23, 1'b1);

    // Read/write collision on word 3 returns the old byte first.
    step(1'b0, 1'b1, '0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd64(), 0, 1'b0);
    step(1'b1, 1'b0, {8{8'h11}}, 0, 1'b0);
    step(1'b0, 1'b1, '0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd64(), 0, 1'b0);
    step(1'b1, 1'b0, {8{8'h22}}, 24, 1'b1);
    step(1'b0, 1'b0, '0, 24, 1'b1);
    step(1'b0, 1'b0, '0, 31, 1'b1);

    // 33 beats without clear wrap onto word 0; then clear drops the status.
    step(1'b0, 1'b1, '0, 0, 1'b0);
    for (int i = 0; i < 33; i++) step(1'b1, 1'b0, rnd64(), $urandom_range(0, 255), 1'b1);
    for (int a = 0; a < 16; a++) step(1'b0, 1'b0, '0, a, 1'b1);
    step(1'b1, 1'b0, rnd64(), 100, 1'b1);
    step(1'b0, 1'b1, '0, 255, 1'b1);
    step(1'b0, 1'b0, '0, 8, 1'b1);

    // Reset mid-line: pointer restarts at word 0, stale data stays readable.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd64(), $urandom_range(0, 255), 1'b1);
    pulse_reset();
    step(1'b1, 1'b0, rnd64(), 0, 1'b0);
    for (int a = 0; a < 48; a++) step(1'b0, 1'b0, '0, a, 1'b1);

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           rnd64(), $urandom_range(0, 255), 1'b1);

    we    = 1'b0;
    clear = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
